// File: rtl/decode_issue_if.sv
// Handshake and data bundle between fetch, the decoder, issue and the decode
// sequencing controller. The controller takes the slave view.
interface decode_issue_if;
    logic         fetch_valid;
    logic         fetch_ready;
    logic [63:0]  fetch_bytes;
    logic [119:0] dec_window;
    logic [4:0]   dec_avail;
    logic [4:0]   dec_len;
    logic         dec_err;
    logic         ins_valid;
    logic         ins_ready;
    logic [119:0] ins_bytes;
    logic [3:0]   ins_len;
    logic [63:0]  ins_pc;
    logic         flush;
    logic [63:0]  flush_pc;
    logic         fault;
    logic [63:0]  fault_pc;

    modport master (
        output fetch_valid, fetch_bytes, dec_len, dec_err, ins_ready, flush, flush_pc,
        input  fetch_ready, dec_window, dec_avail, ins_valid, ins_bytes, ins_len,
               ins_pc, fault, fault_pc
    );

    modport slave (
        input  fetch_valid, fetch_bytes, dec_len, dec_err, ins_ready, flush, flush_pc,
        output fetch_ready, dec_window, dec_avail, ins_valid, ins_bytes, ins_len,
               ins_pc, fault, fault_pc
    );
endinterface

// File: rtl/decode_issue_ctrl.sv
// x86-64 decode sequencer: circular byte queue feeding a 15-byte decode window,
// length-driven pop, registered issue slot, fault halt and flush/redirect.
module decode_issue_ctrl #(
    parameter int QUEUE_BYTES   = 32,
    parameter int FETCH_BYTES   = 8,
    parameter int MAX_INS_BYTES = 15
) (
    input logic          clk,
    input logic          reset,
    decode_issue_if.slave bus
);
    localparam int PTR_W = $clog2(QUEUE_BYTES);
    localparam int OCC_W = PTR_W + 1;
    localparam int WIN_W = MAX_INS_BYTES * 8;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    logic [7:0]       mem_q [QUEUE_BYTES];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, idx_s;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [63:0]      pc_q, pc_d;
    state_e           state_q, state_d;
    logic             ins_valid_q, ins_valid_d;
    logic [WIN_W-1:0] ins_bytes_q, ins_bytes_d;
    logic [3:0]       ins_len_q, ins_len_d;
    logic [63:0]      ins_pc_q, ins_pc_d;
    logic [63:0]      fault_pc_q, fault_pc_d;

    logic [4:0]       avail_s;
    logic [WIN_W-1:0] window_s;
    logic             run_s, fetch_ready_s, push_s, slot_free_s, fault_det_s, accept_s;

    // Window: queue head bytes, zeroed past the valid count.
    always_comb begin
        if (occ_q >= OCC_W'(MAX_INS_BYTES)) begin
            avail_s = 5'(MAX_INS_BYTES);
        end else begin
            avail_s = 5'(occ_q);
        end
        window_s = '0;
        idx_s    = '0;
        for (int i = 0; i < MAX_INS_BYTES; i++) begin
            idx_s = head_q + PTR_W'(i);
            if (5'(i) < avail_s) begin
                window_s[WIN_W-1-8*i -: 8] = mem_q[idx_s];
            end else begin
                window_s[WIN_W-1-8*i -: 8] = 8'h00;
            end
        end
    end

    // Handshake qualifiers; fault detection outranks accept, flush outranks both.
    always_comb begin
        run_s         = (state_q == ST_RUN);
        fetch_ready_s = run_s && !bus.flush &&
                        ((OCC_W'(QUEUE_BYTES) - occ_q) >= OCC_W'(FETCH_BYTES));
        push_s        = bus.fetch_valid && fetch_ready_s;
        slot_free_s   = !ins_valid_q || bus.ins_ready;
        fault_det_s   = run_s && !bus.flush &&
                        ((bus.dec_err && (avail_s != 5'd0)) ||
                         ((bus.dec_len == 5'd0) && (avail_s == 5'(MAX_INS_BYTES))) ||
                         (bus.dec_len > avail_s));
        accept_s      = run_s && !bus.flush && !fault_det_s && !bus.dec_err &&
                        (bus.dec_len != 5'd0) && (bus.dec_len <= avail_s) && slot_free_s;
    end

    // FSM next state: RUN -> FAULT on detected fault, only flush returns to RUN.
    always_comb begin
        state_d    = state_q;
        fault_pc_d = fault_pc_q;
        if (bus.flush) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (fault_det_s) begin
                        state_d    = ST_FAULT;
                        fault_pc_d = pc_q;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Datapath next state: pointers, occupancy, decode PC and issue slot.
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        occ_d       = occ_q;
        pc_d        = pc_q;
        ins_valid_d = ins_valid_q;
        ins_bytes_d = ins_bytes_q;
        ins_len_d   = ins_len_q;
        ins_pc_d    = ins_pc_q;
        if (bus.flush) begin
            head_d      = '0;
            tail_d      = '0;
            occ_d       = '0;
            pc_d        = bus.flush_pc;
            ins_valid_d = 1'b0;
        end else begin
            if (push_s) begin
                tail_d = tail_q + PTR_W'(FETCH_BYTES);
            end else begin
                tail_d = tail_q;
            end
            if (accept_s) begin
                head_d      = head_q + PTR_W'(bus.dec_len);
                pc_d        = pc_q + 64'(bus.dec_len);
                ins_valid_d = 1'b1;
                ins_bytes_d = window_s;
                ins_len_d   = bus.dec_len[3:0];
                ins_pc_d    = pc_q;
            end else if (bus.ins_ready) begin
                ins_valid_d = 1'b0;
            end else begin
                ins_valid_d = ins_valid_q;
            end
            occ_d = occ_q + (push_s ? OCC_W'(FETCH_BYTES) : OCC_W'(0))
                          - (accept_s ? OCC_W'(bus.dec_len) : OCC_W'(0));
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            occ_q       <= '0;
            pc_q        <= 64'd0;
            state_q     <= ST_RUN;
            ins_valid_q <= 1'b0;
            ins_bytes_q <= '0;
            ins_len_q   <= 4'd0;
            ins_pc_q    <= 64'd0;
            fault_pc_q  <= 64'd0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            occ_q       <= occ_d;
            pc_q        <= pc_d;
            state_q     <= state_d;
            ins_valid_q <= ins_valid_d;
            ins_bytes_q <= ins_bytes_d;
            ins_len_q   <= ins_len_d;
            ins_pc_q    <= ins_pc_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    // Byte storage; contents past occupancy are never observed, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                mem_q[tail_q + PTR_W'(i)] <= bus.fetch_bytes[63-8*i -: 8];
            end
        end
    end

    assign bus.fetch_ready = fetch_ready_s;
    assign bus.dec_window  = window_s;
    assign bus.dec_avail   = avail_s;
    assign bus.ins_valid   = ins_valid_q;
    assign bus.ins_bytes   = ins_bytes_q;
    assign bus.ins_len     = ins_len_q;
    assign bus.ins_pc      = ins_pc_q;
    assign bus.fault       = (state_q == ST_FAULT);
    assign bus.fault_pc    = fault_pc_q;
endmodule
